// File: rtl/qspi_fetch_pkg.sv
// Shared definitions for the QSPI fetch arbiter: sequencer states, phase
// lengths and address-nibble selection.
package qspi_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_HI,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_ACK
  } state_t;

  localparam int ADDR_NIBBLES = 6;
  localparam int MODE_NIBBLES = 2;
  localparam int DATA_NIBBLES = 2;

  localparam logic [7:0] DEFAULT_MODE_BYTE = 8'hA5;

  // The flash takes a 24-bit address; only the low 12 bits are ever non-zero.
  function automatic logic [3:0] addr_nibble(input logic [11:0] addr, input logic [2:0] idx);
    logic [3:0] nib;
    case (idx)
      3'd3:    nib = addr[11:8];
      3'd4:    nib = addr[7:4];
      3'd5:    nib = addr[3:0];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/qspi_fetch_arbiter_rr_arb2.sv
// Two-way round-robin selector: on a tie the port not granted last wins.
module qspi_rr_arb2 (
  input  logic       wb_clk_i,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       update,
  output logic [1:0] grant
);

  // 1 = port 1 received the most recent grant
  logic last_reg;

  always_comb begin
    grant = 2'b00;
    if (req0 && (!req1 || last_reg)) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (update) begin
      last_reg <= grant[1];
    end
  end

endmodule

// File: rtl/qspi_fetch_arbiter.sv
// Two-port QSPI flash fetch arbiter with continuous-read streaming: consecutive
// addresses are served by clocking out the next byte without a new command.
module qspi_fetch_arbiter
  import qspi_fetch_pkg::*;
#(
  parameter logic [7:0] MODE_BYTE  = DEFAULT_MODE_BYTE,
  parameter int         DUMMY_CLKS = 4
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        req0,
  input  logic        req1,
  input  logic [11:0] addr0,
  input  logic [11:0] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic [5:0]  rdata,
  output logic        cs_n,
  output logic        sclk,
  output logic [3:0]  dq_out,
  output logic [3:0]  dq_oeb,
  input  logic [3:0]  dq_in
);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg;
  logic        phase_reg;
  logic        sel_reg;
  logic [11:0] addr_reg;
  logic [11:0] last_addr_reg;
  logic        seq_valid_reg;
  logic        stream_open_reg;
  logic [5:0]  data_reg;
  logic [5:0]  rdata_reg;

  logic [1:0]  grant;
  logic        update;
  logic [11:0] pick_addr;
  logic        seq_hit;
  logic        pulse_state;
  logic        last_pulse;
  logic [7:0]  pulse_limit;

  qspi_rr_arb2 u_arb (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .update   (update),
    .grant    (grant)
  );

  assign update    = (state_reg == ST_IDLE) && init_done && (grant != 2'b00);
  assign pick_addr = grant[1] ? addr1 : addr0;
  // 13-bit compare so that 12'hFFF -> 12'h000 never counts as sequential
  assign seq_hit   = seq_valid_reg &&
                     ({1'b0, pick_addr} == ({1'b0, last_addr_reg} + 13'd1));

  assign pulse_state = state_reg inside {ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA};

  always_comb begin
    pulse_limit = 8'd0;
    case (state_reg)
      ST_ADDR:  pulse_limit = 8'(ADDR_NIBBLES - 1);
      ST_MODE:  pulse_limit = 8'(MODE_NIBBLES - 1);
      ST_DUMMY: pulse_limit = 8'(DUMMY_CLKS - 1);
      ST_DATA:  pulse_limit = 8'(DATA_NIBBLES - 1);
      default:  pulse_limit = 8'd0;
    endcase
  end

  assign last_pulse = pulse_state && phase_reg && (cnt_reg == pulse_limit);

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (update) state_next = seq_hit ? ST_DATA : ST_CS_HI;
      ST_CS_HI: state_next = ST_ADDR;
      ST_ADDR:  if (last_pulse) state_next = ST_MODE;
      ST_MODE:  if (last_pulse) state_next = ST_DUMMY;
      ST_DUMMY: if (last_pulse) state_next = ST_DATA;
      ST_DATA:  if (last_pulse) state_next = ST_ACK;
      ST_ACK:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Each SCLK pulse is a low cycle followed by a high cycle; the pulse count
  // advances when the high cycle ends, so dq_out only moves while sclk is low.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      cnt_reg         <= 8'd0;
      phase_reg       <= 1'b0;
      sel_reg         <= 1'b0;
      addr_reg        <= 12'h000;
      last_addr_reg   <= 12'h000;
      seq_valid_reg   <= 1'b0;
      stream_open_reg <= 1'b0;
      data_reg        <= 6'd0;
      rdata_reg       <= 6'd0;
    end else begin
      if (pulse_state && !last_pulse) begin
        phase_reg <= !phase_reg;
        if (phase_reg) begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end else begin
        phase_reg <= 1'b0;
        cnt_reg   <= 8'd0;
      end

      if (update) begin
        sel_reg  <= grant[1];
        addr_reg <= pick_addr;
      end

      if (state_reg == ST_CS_HI) begin
        stream_open_reg <= 1'b1;
      end

      // Capture on the edge that raises sclk
      if (state_reg == ST_DATA && !phase_reg) begin
        if (cnt_reg == 8'd0) begin
          data_reg[5:4] <= dq_in[1:0];
        end else begin
          data_reg[3:0] <= dq_in;
        end
      end

      if (state_reg == ST_DATA && last_pulse) begin
        rdata_reg <= data_reg;
      end

      if (state_reg == ST_ACK) begin
        last_addr_reg <= addr_reg;
        seq_valid_reg <= 1'b1;
      end else if (state_reg == ST_IDLE && !init_done) begin
        seq_valid_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    cs_n   = 1'b0;
    dq_oeb = 4'hF;
    dq_out = 4'h0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    case (state_reg)
      ST_IDLE:  cs_n = !stream_open_reg;
      ST_CS_HI: cs_n = 1'b1;
      ST_ADDR: begin
        dq_oeb = 4'h0;
        dq_out = addr_nibble(addr_reg, cnt_reg[2:0]);
      end
      ST_MODE: begin
        dq_oeb = 4'h0;
        dq_out = (cnt_reg == 8'd0) ? MODE_BYTE[7:4] : MODE_BYTE[3:0];
      end
      ST_ACK: begin
        ack0 = !sel_reg;
        ack1 = sel_reg;
      end
      default: ;
    endcase
  end

  assign sclk  = phase_reg;
  assign rdata = rdata_reg;

endmodule

// File: tb/tb_qspi_fetch_arbiter.sv
// Bench for qspi_fetch_arbiter: QSPI flash model, transaction-level reference
// model checked every cycle, directed scenarios and a randomized phase.
module tb_qspi_fetch_arbiter;

  localparam int DUMMY   = 4;
  localparam int NS_LAT  = 2 + 2 * (6 + 2 + DUMMY + 2);
  localparam int SEQ_LAT = 1 + 2 * 2;

  logic        wb_clk_i  = 1'b0;
  logic        rst_n     = 1'b1;
  logic        init_done = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [11:0] addr0 = 12'h000, addr1 = 12'h000;
  logic        ack0, ack1;
  logic [5:0]  rdata;
  logic        cs_n, sclk;
  logic [3:0]  dq_out, dq_oeb;
  logic [3:0]  dq_in = 4'h0;

  int errors = 0;
  int checks = 0;
  int cyc_p = 0;
  int cs_hi_cnt = 0;
  logic [7:0] mode_b = 8'hA5;

  qspi_fetch_arbiter #(.MODE_BYTE(8'hA5), .DUMMY_CLKS(DUMMY)) dut (
    .wb_clk_i  (wb_clk_i),
    .rst_n     (rst_n),
    .init_done (init_done),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .dq_out    (dq_out),
    .dq_oeb    (dq_oeb),
    .dq_in     (dq_in)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc_p <= cyc_p + 1;

  function automatic logic [7:0] flash_byte(input logic [11:0] a);
    return a[7:0] ^ 8'h5C ^ {4'h0, a[11:8]};
  endfunction

  int m_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, m_cyc, act, exp);
    end
  endtask

  // Flash: counts SCLK rising edges after CS falls, shifts in address and mode,
  // then streams bytes from the captured address onward.
  int          fl_cnt  = 0;
  logic        fl_prev = 1'b0;
  logic [23:0] fl_addr = 24'h0;
  logic [7:0]  fl_mode = 8'h0;

  always @(negedge wb_clk_i) begin
    int k;
    logic [11:0] a;
    logic [7:0]  b;
    if (cs_n !== 1'b0) begin
      fl_cnt  = 0;
      fl_prev = 1'b0;
    end else begin
      if (sclk === 1'b1 && !fl_prev) begin
        if (fl_cnt < 6)      fl_addr = {fl_addr[19:0], dq_out};
        else if (fl_cnt < 8) fl_mode = {fl_mode[3:0], dq_out};
        fl_cnt++;
      end
      fl_prev = (sclk === 1'b1);
    end
    if (cs_n === 1'b1) cs_hi_cnt++;
    if (fl_cnt >= 8 + DUMMY) begin
      k  = fl_cnt - (8 + DUMMY);
      a  = fl_addr[11:0] + 12'(k / 2);
      b  = flash_byte(a);
      dq_in = (k % 2 == 0) ? b[7:4] : b[3:0];
    end else begin
      dq_in = 4'($urandom);
    end
  end

  // Reference model: one transaction at a time, outputs derived from the
  // offset within the transaction's fixed cycle schedule.
  logic        m_on = 1'b0, m_busy = 1'b0, m_seq = 1'b0, m_seq_valid = 1'b0;
  logic        m_last_gnt = 1'b1, m_open = 1'b0, m_port = 1'b0;
  logic [11:0] m_addr = 12'h0, m_last_addr = 12'h0;
  logic [5:0]  m_rdata = 6'h0;
  int          m_gcyc = 0, m_due = 0;

  always @(negedge wb_clk_i) begin
    int d, p;
    logic hit, e_cs, e_sclk;
    logic [3:0]  e_oeb, e_dq;
    logic [23:0] frame;
    logic [7:0]  bt;
    m_cyc++;
    if (m_on) begin
      hit = m_busy && (m_cyc == m_due);
      if (hit) begin
        bt = flash_byte(m_addr);
        m_rdata = bt[5:0];
      end
      e_cs = 1'b0; e_sclk = 1'b0; e_oeb = 4'hF; e_dq = 4'h0;
      if (!m_busy) begin
        e_cs = !m_open;
      end else begin
        d = m_cyc - m_gcyc;
        if (m_seq) begin
          if (d >= 1 && d <= 4) e_sclk = ((d - 1) % 2 == 1);
        end else if (d == 1) begin
          e_cs = 1'b1;
        end else if (d >= 2 && d <= NS_LAT - 1) begin
          p = (d - 2) / 2;
          e_sclk = ((d - 2) % 2 == 1);
          if (p < 6) begin
            e_oeb = 4'h0;
            frame = {12'h000, m_addr};
            e_dq  = frame[4 * (5 - p) +: 4];
          end else if (p < 8) begin
            e_oeb = 4'h0;
            e_dq  = (p == 6) ? mode_b[7:4] : mode_b[3:0];
          end
        end
      end
      chk("ack0", ack0, hit && !m_port);
      chk("ack1", ack1, hit && m_port);
      chk("rdata", rdata, m_rdata);
      chk("cs_n", cs_n, e_cs);
      chk("sclk", sclk, e_sclk);
      chk("dq_oeb", dq_oeb, e_oeb);
      if (e_oeb == 4'h0) chk("dq_out", dq_out, e_dq);
    end
    if (!rst_n) begin
      m_on = 1'b1; m_busy = 1'b0; m_seq_valid = 1'b0; m_last_addr = 12'h0;
      m_last_gnt = 1'b1; m_open = 1'b0; m_rdata = 6'h0;
    end else if (m_on) begin
      if (m_busy) begin
        if (m_cyc == m_due) begin
          m_busy = 1'b0; m_last_addr = m_addr; m_seq_valid = 1'b1;
        end
      end else if (!init_done) begin
        m_seq_valid = 1'b0;
      end else if (req0 || req1) begin
        m_port     = (req0 && req1) ? !m_last_gnt : req1;
        m_last_gnt = m_port;
        m_addr     = m_port ? addr1 : addr0;
        m_seq      = m_seq_valid && (int'(m_addr) == int'(m_last_addr) + 1);
        if (!m_seq) m_open = 1'b1;
        m_busy = 1'b1;
        m_gcyc = m_cyc;
        m_due  = m_cyc + (m_seq ? SEQ_LAT : NS_LAT);
      end
    end
  end

  task automatic do_reset();
    @(posedge wb_clk_i); #1;
    rst_n = 1'b0;
    repeat (2) begin @(posedge wb_clk_i); #1; end
    rst_n = 1'b1;
  endtask

  // Raise the enabled requests; optionally hold init_done low for 'gate'
  // cycles first. Latencies count from the cycle the block may grant.
  task automatic run_reqs(input bit e0, input bit e1, input logic [11:0] a0,
                          input logic [11:0] a1, input int gate,
                          output int first, output int lat0, output int lat1);
    int start, quiet;
    bit d0, d1;
    first = -1; lat0 = -1; lat1 = -1; d0 = !e0; d1 = !e1; quiet = 0;
    @(posedge wb_clk_i); #1;
    if (e0) begin req0 = 1'b1; addr0 = a0; end
    if (e1) begin req1 = 1'b1; addr1 = a1; end
    if (gate > 0) begin
      init_done = 1'b0;
      repeat (gate) begin
        @(posedge wb_clk_i); #1;
        if (sclk || ack0 || ack1) quiet++;
      end
      chk("init_gate_quiet", quiet, 0);
      init_done = 1'b1;
    end
    start = cyc_p;
    for (int i = 0; i < 200 && !(d0 && d1); i++) begin
      @(posedge wb_clk_i); #1;
      if (!d0 && ack0) begin req0 = 1'b0; d0 = 1'b1; lat0 = cyc_p - start; if (first < 0) first = 0; end
      if (!d1 && ack1) begin req1 = 1'b0; d1 = 1'b1; lat1 = cyc_p - start; if (first < 0) first = 1; end
    end
    chk("reqs_done", d0 && d1, 1);
  endtask

  function automatic logic [11:0] next_addr(input logic [11:0] prev);
    int r;
    r = $urandom_range(0, 9);
    if (r < 5)       return prev + 12'd1;
    else if (r == 5) return 12'hFFF;
    else             return 12'($urandom);
  endfunction

  initial begin
    int first, l0, l1, cs_before;

    do_reset();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_dq_out", dq_out, 4'h0);
    chk("rst_dq_oeb", dq_oeb, 4'hF);
    chk("rst_acks", {ack1, ack0}, 2'b00);
    chk("rst_rdata", rdata, 6'h00);
    init_done = 1'b1;

    run_reqs(1, 0, 12'h004, 12'h000, 0, first, l0, l1);
    chk("s1_latency", l0, 30);
    chk("s1_rdata", rdata, 6'h18);
    chk("s1_flash_addr", fl_addr, 24'h000004);
    chk("s1_flash_mode", fl_mode, 8'hA5);

    cs_before = cs_hi_cnt;
    run_reqs(1, 0, 12'h005, 12'h000, 0, first, l0, l1);
    chk("s2_latency", l0, 5);
    chk("s2_rdata", rdata, 6'h19);
    chk("s2_no_cs_pulse", cs_hi_cnt - cs_before, 0);

    do_reset();
    run_reqs(1, 1, 12'h010, 12'h020, 0, first, l0, l1);
    chk("s3_first", first, 0);
    chk("s3_lat0", l0, 30);
    chk("s3_lat1", l1, 61);
    chk("s3_rdata", rdata, 6'h3C);
    run_reqs(1, 1, 12'h030, 12'h040, 0, first, l0, l1);
    chk("s3_tie2_first", first, 0);

    run_reqs(0, 1, 12'h000, 12'hFFF, 0, first, l0, l1);
    chk("s4_fff_rdata", rdata, 6'h2C);
    run_reqs(0, 1, 12'h000, 12'h000, 0, first, l0, l1);
    chk("s4_wrap_latency", l1, 30);
    chk("s4_wrap_rdata", rdata, 6'h1C);

    @(posedge wb_clk_i); #1;
    req0 = 1'b1; addr0 = 12'h200;
    repeat (15) begin @(posedge wb_clk_i); #1; end
    rst_n = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("s5_abort_cs_n", cs_n, 1);
    chk("s5_abort_oeb", dq_oeb, 4'hF);
    chk("s5_abort_ack", ack0, 0);
    rst_n = 1'b1; req0 = 1'b0;
    run_reqs(1, 0, 12'h001, 12'h000, 0, first, l0, l1);
    chk("s5_after_rst_latency", l0, 30);
    chk("s5_rdata", rdata, 6'h1D);

    run_reqs(1, 0, 12'h002, 12'h000, 40, first, l0, l1);
    chk("s6_init_latency", l0, 30);
    chk("s6_rdata", rdata, 6'h1E);

    for (int i = 0; i < 3000; i++) begin
      @(posedge wb_clk_i); #1;
      if (req0 && ack0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin req0 = 1'b1; addr0 = next_addr(addr0); end
      if (req1 && ack1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin req1 = 1'b1; addr1 = next_addr(addr1); end
      if ($urandom_range(0, 99) == 0) init_done = !init_done;
      rst_n = (i != 1500);
    end

    @(posedge wb_clk_i); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qspi_fetch_arbiter.md
QSPI_FETCH_ARBITER -- requirements
Module: qspi_fetch_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous active-low reset: `wb_clk_i` is the sole clock, and `rst_n` is sampled only on the rising edge of `wb_clk_i`.
REQ-002 Parameter: `MODE_BYTE`, default 8'hA5, continuous-read mode bits sent after the address.
REQ-003 Parameter: `DUMMY_CLKS`, default 4, dummy SCLK pulses between mode and data.
REQ-004 Ports (name, direction, width, meaning):
- `wb_clk_i`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `init_done`  in  1  high once the flash is in quad continuous-read mode; no transaction starts while low.
- `req0`, `req1`  in  1  read request for port 0 (instruction fetch) and port 1 (data fetch).
- `addr0`, `addr1`  in  12  byte address for each port.
- `ack0`, `ack1`  out  1  one-cycle pulse meaning the data is valid.
- `rdata`  out  6  fetched word, taken from the low 6 bits of the flash byte.
- `cs_n`  out  1  flash chip select.
- `sclk`  out  1  flash serial clock.
- `dq_out`  out  4  flash data out.
- `dq_oeb`  out  4  flash output-enable-bar (0 = drive).
- `dq_in`  in  4  flash data in.

Function
REQ-005 Handshake: a requester holds reqN and addrN stable until ackN; the block SHALL ignore addrN changes while the request is pending.
REQ-006 Arbitration: in IDLE, when one request is pending, that port is granted. When both are pending, the port not granted last wins; after reset, port 0 has priority.
REQ-007 States: IDLE, CS_HI, ADDR, MODE, DUMMY, DATA, ACK.
- IDLE -> CS_HI on a non-sequential grant.
- IDLE -> DATA on a sequential grant.
- CS_HI -> ADDR -> MODE -> DUMMY -> DATA -> ACK -> IDLE.
REQ-008 Sequential test: a grant is sequential iff `seq_valid` = 1 and the granted address = `last_addr` + 1 computed in 13 bits. The address 12'hFFF followed by 12'h000 is therefore non-sequential.
REQ-009 SCLK half-period SHALL be one `wb_clk_i` cycle. `dq_out` changes only while `sclk` = 0, and the flash samples on the rising edge.
REQ-010 CS_HI: `cs_n` = 1 and `sclk` = 0 for exactly 1 cycle, then `cs_n` = 0 for the remainder of the transaction.
REQ-011 ADDR: 6 nibbles, MSB first: 0, 0, 0, addr[11:8], addr[7:4], addr[3:0], with `dq_oeb` = 4'h0.
REQ-012 MODE: 2 nibbles, `MODE_BYTE`[7:4] then `MODE_BYTE`[3:0], with `dq_oeb` = 4'h0.
REQ-013 DUMMY: `DUMMY_CLKS` pulses with `dq_oeb` = 4'hF.
REQ-014 DATA: 2 pulses.
- `dq_in`[1:0] is sampled on the first rising edge into `rdata`[5:4].
- `dq_in`[3:0] is sampled on the second rising edge into `rdata`[3:0].
REQ-015 Latency from grant cycle to ack cycle SHALL be:
- 30 cycles for a non-sequential access (1 CS_HI + 2×(6+2+4+2) + 1 ACK) with default parameters.
- 5 cycles for a sequential access.
REQ-016 ACK: ackN = 1 for exactly one cycle with `rdata` valid. `rdata` holds its value until the next ACK. `last_addr` ← granted address and `seq_valid` ← 1.
REQ-017 Between transactions, `cs_n` SHALL remain 0 with `sclk` = 0 so that the flash stream stays open.
REQ-018 If `init_done` falls, the block SHALL finish any transaction in flight, then clear `seq_valid` and refuse new grants until `init_done` rises.
REQ-019 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-020 On reset the outputs SHALL take these values: `cs_n` = 1, `sclk` = 0, `dq_out` = 4'h0, `dq_oeb` = 4'hF, ack0 = ack1 = 0, `rdata` = 0.
REQ-021 On reset the internal state SHALL be: state = IDLE, `seq_valid` = 0, `last_addr` = 0, last-grant pointer = port 1 (so port 0 wins the first tie).
REQ-022 A reset asserted mid-transaction SHALL abort the transaction within the same edge, with no ack issued. The next access after reset SHALL be non-sequential.

Structure
REQ-023 A shared package `qspi_fetch_pkg` SHALL hold the state enum, the nibble counts (ADDR = 6, MODE = 2, DATA = 2) and the default `MODE_BYTE`.
REQ-024 Two-way round-robin selection SHALL be one sub-module, `qspi_rr_arb2`, with ports req0/req1, update, and grant.

Verification
REQ-025 The bench SHALL cover these directed scenarios with a QSPI flash model:
- Reset, then req0 with addr0 = 12'h004 → CS_HI, then nibbles 0,0,0,0,0,4, then 4'hA, 4'h5, 4 dummy pulses; ack0 at cycle 30 with `rdata` = model[0x004][5:0].
- A second req0 at 12'h005 → no `cs_n` pulse; ack0 5 cycles after grant.
- req0 = 12'h010 and req1 = 12'h020 in the same cycle after reset → port 0 is served first, then port 1 via a non-sequential restart; a further tie goes to port 0.
- `last_addr` = 12'hFFF, then request 12'h000 → full restart with a 30-cycle latency.
- `rst_n` low at cycle 15 of an access → `cs_n` = 1, `dq_oeb` = 4'hF and no ack on the next edge; the next access is non-sequential.
- `init_done` = 0 with requests pending → no SCLK activity and no ack until `init_done` rises.
